// File: rtl/brpred_pkg.sv
// Shared constants and counter arithmetic for the branch history table.
package brpred_pkg;

  localparam int BRPRED_IDX_W = 4;
  localparam int BRPRED_CNT_W = 2;
  localparam int CNT_MAX_W    = 4;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // Weakly not-taken: all ones below the MSB.
  function automatic cnt_t cnt_rst_val(input int unsigned w);
    return cnt_t'((32'd1 << (w - 32'd1)) - 32'd1);
  endfunction

  function automatic cnt_t cnt_max(input int unsigned w);
    return cnt_t'((32'd1 << w) - 32'd1);
  endfunction

  function automatic cnt_t sat_step(
    input cnt_t        cnt,
    input logic        up,
    input int unsigned w
  );
    cnt_t res;
    res = cnt;
    if (up) begin
      if (cnt != cnt_max(w)) res = cnt + cnt_t'(1);
    end else begin
      if (cnt != '0) res = cnt - cnt_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/brpred_sat_counter.sv
// One table entry: saturating up/down counter, sync reset to weakly
// not-taken, steps only when enabled.
module brpred_sat_counter
  import brpred_pkg::*;
#(
  parameter int CNT_W = BRPRED_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] RstVal = CNT_W'(cnt_rst_val(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = CNT_W'(sat_step(cnt_t'(cnt_q), up_i, CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RstVal;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table; define BRPRED_GSHARE_EN to hash the
// index with a global history register (gshare).
module branch_predictor_bht
  import brpred_pkg::*;
#(
  parameter int IDX_W = BRPRED_IDX_W,
  parameter int CNT_W = BRPRED_CNT_W,
  parameter int GHR_W = IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      pc_i,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int Entries = 1 << IDX_W;

  if (CNT_W < 2 || CNT_W > 4 || GHR_W > IDX_W || GHR_W < 1)
  begin : g_bad_cfg
    $error("branch_predictor_bht: illegal parameters");
  end

  logic             upd_en;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] look_idx;
  logic [CNT_W-1:0] cnt [Entries];
  logic             unused_pc;

  assign upd_en    = upd_valid_i & ~stall;
  assign pc_idx    = pc_i[IDX_W+1:2];
  assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0]};

`ifdef BRPRED_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Shift left, newest outcome into bit 0, MSB falls off.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_en) ghr_d = GHR_W'({ghr_q, upd_taken_i});
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign look_idx = pc_idx ^ IDX_W'(ghr_q);
`else
  assign look_idx = pc_idx;
`endif

  for (genvar i = 0; i < Entries; i++) begin : g_entry
    brpred_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en_i (upd_en && (upd_idx_i == IDX_W'(i))),
      .up_i (upd_taken_i),
      .cnt_o(cnt[i])
    );
  end

  // Reads the registered value, so a same-cycle update is not bypassed.
  assign pred_taken_o = cnt[look_idx][CNT_W-1];
  assign pred_idx_o   = look_idx;

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning index width; the table holds 2**IDX_W entries.
REQ-002 SHALL have parameter CNT_W, default 2, meaning saturating counter width per entry (legal range 2..4).
REQ-003 SHALL have parameter GHR_W, default IDX_W, meaning global history width (used only under BRPRED_GSHARE_EN; GHR_W <= IDX_W).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the reset: synchronous and active-high.
REQ-006 SHALL have port stall, input, 1, meaning pipeline stall; high blocks table and history updates.
REQ-007 SHALL have port pc_i, input, 32, meaning fetch PC of the lookup (word aligned; bits [1:0] ignored).
REQ-008 SHALL have port pred_taken_o, output, 1, meaning prediction for pc_i (1 = taken).
REQ-009 SHALL have port pred_idx_o, output, IDX_W, meaning the table index used for this lookup; the pipeline carries it to the update.
REQ-010 SHALL have port upd_valid_i, input, 1, meaning a resolved branch is presented this cycle.
REQ-011 SHALL have port upd_idx_i, input, IDX_W, meaning the index to update (the earlier pred_idx_o).
REQ-012 SHALL have port upd_taken_i, input, 1, meaning the actual branch outcome.

Function
REQ-013 SHALL compute lookup index = pc_i[IDX_W+1:2]; pred_idx_o SHALL equal that index combinationally.
REQ-014 SHALL drive pred_taken_o combinationally (zero latency) as the MSB of the addressed counter.
REQ-015 SHALL apply an update only when upd_valid_i=1 and stall=0; one update per cycle at most.
REQ-016 SHALL increment the counter on upd_taken_i=1 and decrement it on upd_taken_i=0, saturating at 2**CNT_W-1 and 0 (no wrap).
REQ-017 SHALL leave all other entries unchanged during an update.
REQ-018 SHALL, when an update and a lookup hit the same index in the same cycle, return the pre-update value for the lookup (no bypass); the new value is visible from the next cycle.
REQ-019 SHALL hold all state while stall=1, including while upd_valid_i is held high; the update applies exactly once, in the first cycle with stall=0.
REQ-020 SHALL ignore upd_taken_i while upd_valid_i=0.

Reset
REQ-021 SHALL set every counter to weakly not-taken, 2**(CNT_W-1)-1 (01 for CNT_W=2), in the cycle rst is sampled high.
REQ-022 SHALL clear the GHR to 0 on reset when it is present.
REQ-023 SHALL give reset priority over a simultaneous update; after reset, pred_taken_o=0 for every pc_i.
REQ-024 SHALL apply a mid-operation reset in full in one cycle with no stale entries retained.

Configuration
REQ-025 SHALL support macro BRPRED_GSHARE_EN; when it is undefined, behaviour is REQ-013 exactly and no GHR exists.
REQ-026 SHALL, with BRPRED_GSHARE_EN defined, form the index as pc_i[IDX_W+1:2] XOR zero-extended GHR; pred_idx_o reports the hashed index.
REQ-027 SHALL, with BRPRED_GSHARE_EN defined, shift upd_taken_i into GHR bit 0 (discarding the MSB) on every applied update, in the same edge as the counter update.

Structure
REQ-028 SHALL place in shared package brpred_pkg: the counter reset value function of CNT_W, the saturating increment/decrement function, and the default parameter constants.
REQ-029 SHALL use one sub-module, brpred_sat_counter (CNT_W-wide saturating up/down counter with sync reset and enable), instantiated once per entry by generate.

Verification
REQ-030 SHALL be verified by: reset, then lookup pc_i=0x40 -> pred_idx_o=0, pred_taken_o=0.
REQ-031 SHALL be verified by: two updates to idx 0 with taken=1 -> counter 01->10->11; pred_taken_o=1 after the first; a third taken update stays at 11.
REQ-032 SHALL be verified by: from 11, four not-taken updates -> 10,01,00,00; no wrap to 11.
REQ-033 SHALL be verified by: upd_valid_i=1 held for 3 cycles with stall=1 for the first 2 -> exactly one increment, on cycle 3.
REQ-034 SHALL be verified by: a same-cycle update and lookup on idx 5 -> the lookup returns the old MSB and the new value appears the next cycle; rst asserted in that same cycle -> entry 5 becomes 01.
REQ-035 SHALL be verified by: under BRPRED_GSHARE_EN, IDX_W=4, after taken updates T,T,N (GHR=0110), lookup pc_i=0x24 -> pred_idx_o=1001^0110=1111.
